// File: rtl/imem_loader.sv
// Purpose : fill instruction memory from a byte-wide host stream, holding the core until the image is in.
// Latency : mem_we pulses 1 cycle after the 4th byte of a word is accepted; done rises with the last write.
// Backpr. : in_ready is a decode of the registered state (1 while loading); in_valid gaps hold all state.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   start               one-cycle pulse arming a load (honoured in IDLE and DONE only)
//   in_data/in_valid/in_ready   byte stream: 2 header bytes (word count N, LE) then N*4 data bytes
//   mem_we/mem_addr/mem_wdata   instruction memory write port (byte address, LE 32-bit word)
//   core_hold           1 holds fetch/core in reset; 0 only once the image is complete
//   done                load complete
//   err                 header N exceeded DEPTH; excess words are drained, not written
//   words_written       words written in the current load (saturates at DEPTH)
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             core_hold,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_written
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [31:0]      DEPTH_U = 32'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       part_q, part_d;     // bytes 0..2 of the word being assembled
    logic [CNT_W-1:0]  n_q, n_d;           // header word count
    logic [CNT_W-1:0]  ww_q, ww_d;
    logic [CNT_W-1:0]  rem_q, rem_d;       // words still to discard in DRAIN
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              accept;
    logic [15:0]       hdr_n;
    logic              hdr_zero;
    logic              hdr_over;
    logic [CNT_W-1:0]  ww_inc;
    logic              at_depth;
    logic              word_last;

    assign accept    = in_valid && in_ready;
    assign hdr_n     = {in_data, n_q[7:0]};
    assign hdr_zero  = (hdr_n == 16'd0);
    assign hdr_over  = (32'(hdr_n) > DEPTH_U);
    assign ww_inc    = ww_q + CNT_W'(1);
    assign at_depth  = (ww_inc == DEPTH_C);
    assign word_last = (ww_inc == n_q);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_HDR0;
            S_HDR0:  if (accept) state_d = S_HDR1;
            S_HDR1:  if (accept) state_d = hdr_zero ? S_DONE : S_DATA;
            S_DATA: begin
                if (accept && lane_q == 2'd3) begin
                    // An oversized image stops writing at the last memory word.
                    if (err_q && at_depth) begin
                        state_d = S_DRAIN;
                    end else if (word_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && lane_q == 2'd3 && rem_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  if (start) state_d = S_HDR0;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        in_ready  = 1'b0;
        core_hold = 1'b1;
        done      = 1'b0;
        case (state_q)
            S_HDR0, S_HDR1, S_DATA, S_DRAIN: in_ready = 1'b1;
            S_DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        lane_d  = lane_q;
        part_d  = part_q;
        n_d     = n_q;
        ww_d    = ww_q;
        rem_d   = rem_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    err_d  = 1'b0;
                    ww_d   = '0;
                    lane_d = 2'd0;
                end
            end
            S_HDR0: begin
                if (accept) n_d = CNT_W'(in_data);
            end
            S_HDR1: begin
                if (accept) begin
                    n_d    = CNT_W'(hdr_n);
                    err_d  = hdr_over;
                    lane_d = 2'd0;
                end
            end
            S_DATA: begin
                if (accept) begin
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: part_d[7:0]   = in_data;
                        2'd1: part_d[15:8]  = in_data;
                        2'd2: part_d[23:16] = in_data;
                        default: begin
                            wdata_d = {in_data, part_q};
                            addr_d  = 32'({ww_q, 2'b00});
                            we_d    = 1'b1;
                            ww_d    = ww_inc;
                            if (err_q && at_depth) rem_d = n_q - DEPTH_C;
                        end
                    endcase
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) rem_d = rem_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q  <= 2'd0;
            part_q  <= '0;
            n_q     <= '0;
            ww_q    <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            lane_q  <= lane_d;
            part_q  <= part_d;
            n_q     <= n_d;
            ww_q    <= ww_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign err           = err_q;
    assign words_written = ww_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to instruction fetch: fills the instruction memory's write port from a byte-wide host stream before the core runs.
- Holds the core (PC/fetch logic) in reset via core_hold until the image is fully written, then releases it.
- Image stores little-endian 32-bit words at byte addresses 0, 4, 8, … so the PC-based fetch reads them back unchanged.

Parameters:
- DEPTH, 1024, instruction memory capacity in 32-bit words.
- CNT_W, 16, width of the word-count header and of words_written.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  single-cycle pulse; arms a new load
- in_data  input  8  host byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  output  32  byte address of the word being written
- mem_wdata  output  32  assembled instruction word
- core_hold  output  1  active-high reset/hold to fetch and core
- done  output  1  load complete, core released
- err  output  1  header word count exceeded DEPTH
- words_written  output  CNT_W  words written in the current load

Behaviour:
- Reset (rst=0, async): state=IDLE, core_hold=1, done=0, err=0, mem_we=0, in_ready=0, mem_addr=0, mem_wdata=0, words_written=0, byte lane=0.
- Byte transfer occurs when in_valid && in_ready on a rising edge. in_data is ignored otherwise. in_ready is a registered function of state only: 1 in HDR0, HDR1, DATA, DRAIN; 0 in IDLE, DONE.
- IDLE: start=1 -> HDR0; clear err, words_written, byte lane.
- HDR0: accepted byte -> N[7:0]; go to HDR1.
- HDR1: accepted byte -> N[15:8].
  - If N==0: go to DONE.
  - Else: go to DATA.
  - If N>DEPTH: set err the same edge.
- DATA: bytes assembled little-endian. Lane 0->bits[7:0] … lane 3->bits[31:24].
  - On the lane-3 accept: mem_wdata is registered with the full word, mem_addr = words_written*4, mem_we=1 in the next cycle only. words_written then increments, and the lane wraps to 0.
  - Write latency: mem_we is asserted exactly 1 cycle after the 4th byte is accepted.
  - When the word written is the N-th: go to DONE in the same cycle mem_we is high.
  - When the word written is the DEPTH-th and N>DEPTH: go to DRAIN instead of DONE.
- DRAIN: accept and discard the remaining (N-DEPTH)*4 bytes, with no writes. Then go to DONE. err stays 1.
- DONE: core_hold=0, done=1 (registered, same cycle the state is entered). start=1 -> HDR0 with core_hold=1, done=0, counters cleared. err keeps its value until the next start.
- start in HDR0/HDR1/DATA/DRAIN is ignored. No restart mid-load.
- in_valid gaps of any length are allowed. State, lane and partial word are held.
- mem_addr never exceeds (DEPTH-1)*4. words_written saturates at DEPTH.
- rst asserted mid-load: immediate return to reset values. Partially written memory contents are not cleared. core_hold is 1 throughout reset.
- mem_we and in_ready are never X after reset. mem_wdata and mem_addr hold their last values when mem_we=0.

Test Plan:
- Basic load:
  - Stimulus: rst low 3 cycles, then high; start pulse; bytes 02 00 13 05 A0 00 93 05 50 00, in_valid held high.
  - Required: mem_we pulse #1 with addr 0x0, data 0x00A00513; pulse #2 with addr 0x4, data 0x00500593.
  - Each pulse is 1 cycle after its 4th byte. done=1 and core_hold=0 in the cycle of pulse #2. words_written=2.
- Empty image:
  - Stimulus: start, bytes 00 00.
  - Required: DONE immediately after the 2nd byte, no mem_we, done=1, err=0.
- Backpressure/gaps:
  - Stimulus: same image as the basic load, in_valid toggling 1,0,0,1… with random gaps.
  - Required: identical writes and data. in_ready stays 1 during gaps. No extra mem_we.
- Overflow, DEPTH=4:
  - Stimulus: header 06 00, 24 data bytes.
  - Required: err=1 from the 2nd header byte; exactly 4 writes, to addrs 0x0–0xC; remaining 8 bytes accepted with no writes; then done=1, words_written=4.
- Reset mid-load:
  - Stimulus: rst low after 5 data bytes.
  - Required: asynchronously core_hold=1, in_ready=0, mem_we=0, state IDLE. A fresh start plus full image loads correctly from addr 0.
- Reload:
  - Stimulus: after done, pulse start, then a 1-word image DE AD BE EF (header 01 00).
  - Required: core_hold=1 from the start edge; one write, addr 0x0, data 0xEFBEADDE; then done=1.
